bram_readback_checker: RTL and testbench

Read-side verifier for the block-RAM self-test. On a start pulse, it reads DEPTH consecutive words from the BRAM read port (port B), starting at address 0. Each returned word is compared against the incrementing pattern the write-side test loaded. The block reports a pass/fail flag, a mismatch count and the first failing address/data. It connects directly to the port-B pins of the block-memory generator instance, alongside the existing write/read sequencer, and its status outputs are intended for debug marking.

---
 rtl/bram_readback_checker.sv | 130 +++++++++++++
 tb/tb_bram_readback_checker.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/bram_readback_checker.sv
// bram_readback_checker: sweeps BRAM port B from address 0 and checks every word against an incrementing pattern
module bram_readback_checker #(
  parameter int DATA_W         = 16,
  parameter int ADDR_W         = 20,
  parameter int DEPTH          = 2048,
  parameter int RD_LATENCY     = 1,
  parameter int PATTERN_OFFSET = 0,
  parameter int ERR_W          = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  output logic              enb,
  output logic [ADDR_W-1:0] addrb,
  input  logic [DATA_W-1:0] doutb,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ERR_W-1:0]  err_count,
  output logic [ADDR_W-1:0] first_err_addr,
  output logic [DATA_W-1:0] first_err_data
);
  localparam int SUM_W = ADDR_W > DATA_W ? ADDR_W : DATA_W;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [1:0] DRAIN_CYC = 2'(RD_LATENCY - 1);
  typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_DONE} state_t;
  state_t r_state;
  logic r_enb, r_busy, r_done, r_pass;
  logic [ADDR_W-1:0] r_addr;
  logic [1:0] r_drain;
  logic [RD_LATENCY-1:0] r_vld;
  logic [RD_LATENCY-1:0][ADDR_W-1:0] r_tag;
  logic [ERR_W-1:0] r_err_cnt;
  logic [ADDR_W-1:0] r_err_addr;
  logic [DATA_W-1:0] r_err_data;
  logic w_go, w_flush, w_vld, w_hit;
  logic [ADDR_W-1:0] w_tag;
  logic [DATA_W-1:0] w_exp;
  logic [ERR_W-1:0] w_err_nxt;
  assign w_go      = r_state == S_IDLE && start;
  assign w_flush   = abort && r_busy;
  assign w_vld     = r_vld[RD_LATENCY-1];
  assign w_tag     = r_tag[RD_LATENCY-1];
  assign w_exp     = DATA_W'(SUM_W'(w_tag) + SUM_W'(PATTERN_OFFSET));
  assign w_hit     = w_vld && doutb != w_exp;
  assign w_err_nxt = w_hit && !(&r_err_cnt) ? r_err_cnt + 1'b1 : r_err_cnt;
  assign enb            = r_enb;
  assign addrb          = r_addr;
  assign busy           = r_busy;
  assign done           = r_done;
  assign pass           = r_pass;
  assign err_count      = r_err_cnt;
  assign first_err_addr = r_err_addr;
  assign first_err_data = r_err_data;
  // run sequencer: issue DEPTH reads, drain the read latency, then pulse done with the verdict
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_state <= S_IDLE;
      r_enb   <= 1'b0;
      r_addr  <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_pass  <= 1'b0;
      r_drain <= '0;
    end else begin
      case (r_state)
        S_IDLE:
          if (start) begin
            r_state <= S_READ;
            r_enb   <= 1'b1;
            r_addr  <= '0;
            r_busy  <= 1'b1;
            r_pass  <= 1'b0;
          end
        S_READ:
          if (abort) begin
            r_state <= S_IDLE;
            r_enb   <= 1'b0;
            r_busy  <= 1'b0;
          end else if (r_addr == LAST_ADDR) begin
            r_state <= S_DRAIN;
            r_enb   <= 1'b0;
            r_drain <= DRAIN_CYC;
          end else
            r_addr <= r_addr + 1'b1;
        S_DRAIN:
          if (abort) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else if (r_drain == 2'd0) begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_pass  <= w_err_nxt == '0;
          end else
            r_drain <= r_drain - 1'b1;
        default: begin
          r_state <= S_IDLE;
          r_done  <= 1'b0;
        end
      endcase
    end
  // valid/tag shift line matching the BRAM read latency; abort discards reads in flight
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_vld <= '0;
      r_tag <= '0;
    end else begin
      r_vld <= w_flush ? '0 : RD_LATENCY'({r_vld, r_enb});
      r_tag <= (RD_LATENCY*ADDR_W)'({r_tag, r_addr});
    end
  // mismatch count (saturating) and capture of the first failing address and data
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_err_cnt  <= '0;
      r_err_addr <= '0;
      r_err_data <= '0;
    end else if (w_go) begin
      r_err_cnt  <= '0;
      r_err_addr <= '0;
      r_err_data <= '0;
    end else if (w_hit) begin
      r_err_cnt <= w_err_nxt;
      if (r_err_cnt == '0) begin
        r_err_addr <= w_tag;
        r_err_data <= doutb;
      end
    end
endmodule

// File: tb/tb_bram_readback_checker.sv
// tb_bram_readback_checker: vector table, corner sequences and randomized runs against a pattern-level model
module tb_bram_readback_checker;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;
  logic start0, abort0, enb0, busy0, done0, pass0;
  logic [19:0] addrb0, fa0;
  logic [15:0] dout0, fd0;
  logic [7:0] ec0;
  logic start1, abort1, enb1, busy1, done1, pass1;
  logic [19:0] addrb1, fa1;
  logic [15:0] dout1, fd1;
  logic [7:0] ec1;
  logic start2, abort2, enb2, busy2, done2, pass2;
  logic [19:0] addrb2, fa2;
  logic [15:0] dout2, fd2;
  logic [7:0] ec2;
  bram_readback_checker u0 (.clk(clk), .rst(rst), .start(start0), .abort(abort0), .enb(enb0), .addrb(addrb0),
    .doutb(dout0), .busy(busy0), .done(done0), .pass(pass0), .err_count(ec0), .first_err_addr(fa0), .first_err_data(fd0));
  bram_readback_checker #(.DEPTH(16), .RD_LATENCY(3), .PATTERN_OFFSET(5)) u1 (.clk(clk), .rst(rst), .start(start1),
    .abort(abort1), .enb(enb1), .addrb(addrb1), .doutb(dout1), .busy(busy1), .done(done1), .pass(pass1),
    .err_count(ec1), .first_err_addr(fa1), .first_err_data(fd1));
  bram_readback_checker #(.DEPTH(1)) u2 (.clk(clk), .rst(rst), .start(start2), .abort(abort2), .enb(enb2),
    .addrb(addrb2), .doutb(dout2), .busy(busy2), .done(done2), .pass(pass2), .err_count(ec2),
    .first_err_addr(fa2), .first_err_data(fd2));
  logic [15:0] mem0 [2048];
  logic [15:0] mem1 [16];
  logic [15:0] h0, h2, d2val;
  logic [15:0] hist1 [3];
  bit early1;
  always @(posedge clk) h0 <= enb0 ? mem0[addrb0[10:0]] : 16'h0;
  always @(posedge clk) begin
    hist1[0] <= enb1 ? mem1[addrb1[3:0]] : 16'h0;
    hist1[1] <= hist1[0];
    hist1[2] <= hist1[1];
  end
  always @(posedge clk) h2 <= enb2 ? d2val : 16'h0;
  assign dout0 = h0;
  assign dout1 = early1 ? hist1[1] : hist1[2];
  assign dout2 = h2;
  int npass = 0, ntot = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    ntot++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask
  function automatic void model0(output bit p, output int ec, output int fa, output int fd);
    int n = 0;
    fa = 0;
    fd = 0;
    for (int a = 0; a < 2048; a++)
      if (mem0[a] != 16'(a)) begin
        if (n == 0) begin fa = a; fd = int'(mem0[a]); end
        n++;
      end
    ec = n > 255 ? 255 : n;
    p = n == 0;
  endfunction
  function automatic void model1(input bit early, output bit p, output int ec, output int fa, output int fd);
    int n = 0;
    logic [15:0] seen;
    fa = 0;
    fd = 0;
    for (int k = 0; k < 16; k++) begin
      seen = !early ? mem1[k] : (k < 15 ? mem1[k+1] : 16'h0);
      if (seen != 16'(k + 5)) begin
        if (n == 0) begin fa = k; fd = int'(seen); end
        n++;
      end
    end
    ec = n > 255 ? 255 : n;
    p = n == 0;
  endfunction
  task automatic run0(input int st_at, input int ab_at, input int rs_at, output int dlat, output int ndone,
                      output int nenb, output bit sweep_ok);
    dlat = 0; ndone = 0; nenb = 0; sweep_ok = 1;
    start0 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0;
    for (int lat = 1; lat <= 2100; lat++) begin
      rst = 1'b1;
      if (done0) begin ndone++; if (dlat == 0) dlat = lat; end
      if (enb0) begin if (addrb0 != 20'(nenb)) sweep_ok = 0; nenb++; end
      if (lat == ab_at + 1) chk("abort_busy", {31'b0, busy0}, 0);
      start0 = lat == st_at;
      abort0 = lat == ab_at;
      if (lat == rs_at) begin
        rst = 1'b0;
        #1;
        chk("rst_flags", {28'b0, enb0, busy0, done0, pass0}, 0);
        chk("rst_addrb", addrb0, 0);
        chk("rst_err_count", ec0, 0);
        chk("rst_first_err", {fa0, fd0}, 0);
      end
      @(posedge clk); #1;
    end
    rst = 1'b1;
  endtask
  task automatic run1(input bit early, output int dlat, output int ndone);
    early1 = early; dlat = 0; ndone = 0;
    start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    for (int lat = 1; lat <= 40; lat++) begin
      if (done1) begin ndone++; if (dlat == 0) dlat = lat; end
      @(posedge clk); #1;
    end
  endtask
  typedef struct {
    int caddr; logic [15:0] cdata; bit sat;
    bit exp_pass; int exp_ec; int exp_fa; int exp_fd;
  } vec_t;
  vec_t vt [5];
  initial begin
    int dlat, ndone, nenb, ec, fa, fd, nc;
    bit sw, p;
    vt[0] = '{-1,     16'h0000, 0, 1, 0,   0,      0};
    vt[1] = '{'h123,  16'hBEEF, 0, 0, 1,   'h123,  'hBEEF};
    vt[2] = '{-1,     16'h0000, 1, 0, 255, 0,      'hFFFF};
    vt[3] = '{'h7FF,  16'h1234, 0, 0, 1,   'h7FF,  'h1234};
    vt[4] = '{0,      16'h8000, 0, 0, 1,   0,      'h8000};
    start0 = 0; abort0 = 0; start1 = 0; abort1 = 0; start2 = 0; abort2 = 0;
    early1 = 0; d2val = 16'h0;
    for (int a = 0; a < 2048; a++) mem0[a] = 16'(a);
    for (int k = 0; k < 16; k++) mem1[k] = 16'(k + 5);
    rst = 1'b1;
    #2 rst = 1'b0;
    #1;
    chk("reset_flags", {28'b0, enb0, busy0, done0, pass0}, 0);
    chk("reset_addrb", addrb0, 0);
    chk("reset_err", {ec0, fa0, fd0}, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      for (int a = 0; a < 2048; a++) mem0[a] = vt[i].sat ? 16'hFFFF : 16'(a);
      if (vt[i].caddr >= 0) mem0[vt[i].caddr] = vt[i].cdata;
      run0(-1, -1, -1, dlat, ndone, nenb, sw);
      chk($sformatf("v%0d_latency", i), dlat, 2050);
      chk($sformatf("v%0d_ndone", i), ndone, 1);
      chk($sformatf("v%0d_pass", i), {31'b0, pass0}, {31'b0, vt[i].exp_pass});
      chk($sformatf("v%0d_err_count", i), ec0, vt[i].exp_ec);
      chk($sformatf("v%0d_first_addr", i), fa0, vt[i].exp_fa);
      chk($sformatf("v%0d_first_data", i), fd0, vt[i].exp_fd);
      if (i == 0) begin
        chk("sweep_enb_cycles", nenb, 2048);
        chk("sweep_addr_order", {31'b0, sw}, 1);
        chk("addrb_hold", addrb0, 2047);
      end
    end
    for (int a = 0; a < 2048; a++) mem0[a] = 16'(a);
    mem0[40] = 16'h0BAD;
    run0(100, -1, -1, dlat, ndone, nenb, sw);
    chk("busy_start_latency", dlat, 2050);
    chk("busy_start_ndone", ndone, 1);
    chk("busy_start_err", ec0, 1);
    chk("busy_start_first", fa0, 40);
    run0(-1, 500, -1, dlat, ndone, nenb, sw);
    chk("abort_ndone", ndone, 0);
    chk("abort_pass", {31'b0, pass0}, 0);
    chk("abort_partial_err", ec0, 1);
    mem0[40] = 16'(40);
    run0(-1, -1, -1, dlat, ndone, nenb, sw);
    chk("after_abort_latency", dlat, 2050);
    chk("after_abort_pass", {31'b0, pass0}, 1);
    run0(-1, -1, 700, dlat, ndone, nenb, sw);
    chk("reset_run_ndone", ndone, 0);
    run0(-1, -1, -1, dlat, ndone, nenb, sw);
    chk("after_reset_latency", dlat, 2050);
    chk("after_reset_pass", {31'b0, pass0}, 1);
    for (int r = 0; r < 4; r++) begin
      nc = $urandom_range(0, 300);
      for (int a = 0; a < 2048; a++) mem0[a] = 16'(a);
      repeat (nc) mem0[$urandom_range(0, 2047)] = 16'($urandom);
      model0(p, ec, fa, fd);
      run0(-1, -1, -1, dlat, ndone, nenb, sw);
      chk($sformatf("rnd%0d_latency", r), dlat, 2050);
      chk($sformatf("rnd%0d_pass", r), {31'b0, pass0}, {31'b0, p});
      chk($sformatf("rnd%0d_err_count", r), ec0, ec);
      chk($sformatf("rnd%0d_first", r), {fa0, fd0}, {12'(fa), 16'(fd)});
    end
    run1(0, dlat, ndone);
    chk("lat3_latency", dlat, 20);
    chk("lat3_ndone", ndone, 1);
    chk("lat3_pass", {31'b0, pass1}, 1);
    run1(1, dlat, ndone);
    chk("early_err_count", ec1, 16);
    chk("early_pass", {31'b0, pass1}, 0);
    chk("early_first", {fa1, fd1}, {20'd0, 16'd6});
    for (int r = 0; r < 10; r++) begin
      for (int k = 0; k < 16; k++) mem1[k] = $urandom_range(0, 3) == 0 ? 16'($urandom) : 16'(k + 5);
      p = bit'($urandom_range(0, 1));
      model1(p, sw, ec, fa, fd);
      run1(p, dlat, ndone);
      chk($sformatf("rnd1_%0d_latency", r), dlat, 20);
      chk($sformatf("rnd1_%0d_pass", r), {31'b0, pass1}, {31'b0, sw});
      chk($sformatf("rnd1_%0d_err_count", r), ec1, ec);
      chk($sformatf("rnd1_%0d_first", r), {fa1, fd1}, {20'(fa), 16'(fd)});
    end
    for (int r = 0; r < 2; r++) begin
      d2val = r == 0 ? 16'h0000 : 16'h0007;
      dlat = 0;
      start2 = 1'b1;
      @(posedge clk); #1;
      start2 = 1'b0;
      for (int lat = 1; lat <= 10; lat++) begin
        if (done2 && dlat == 0) dlat = lat;
        @(posedge clk); #1;
      end
      chk($sformatf("depth1_%0d_latency", r), dlat, 3);
      chk($sformatf("depth1_%0d_pass", r), {31'b0, pass2}, r == 0 ? 1 : 0);
      chk($sformatf("depth1_%0d_err", r), {ec2, fd2}, r == 0 ? 0 : {8'd1, 16'h0007});
    end
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
